tank_monitor_capture: RTL and testbench

- Downstream consumer of the memory subsystem's per-tank monitor outputs, which are currently left open at the top level.
- Snapshots one full major cycle of a selected mercury tank's serial monitor stream into parallel words.
- Presents the words, with their index, on a valid/ready stream toward a display or host interface.
- Runs in digit time: one clk per digit period, aligned to the digit pulse generator.

---
 rtl/tank_monitor_if.sv | 24 ++
 rtl/tank_monitor_capture.sv | 211 +++++++++++++++++++++
 tb/tb_tank_monitor_capture.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tank_monitor_if.sv
// -----------------------------------------------------------------------------
// tank_monitor_if
// Valid/ready word stream carrying captured tank words toward a display or
// host interface.
//   word_valid : producer has a word at the head of its buffer
//   word_ready : consumer accepts the head word on this clk
//   word_data  : captured word, digit 0 in bit 0
//   word_index : minor-cycle index of word_data
// Modports: master (capture block side), slave (consumer side).
// -----------------------------------------------------------------------------
interface tank_monitor_if #(
   parameter int WORD_BITS = 36,
   parameter int IDX_W     = 4
);
   logic                 word_valid;
   logic                 word_ready;
   logic [WORD_BITS-1:0] word_data;
   logic [IDX_W-1:0]     word_index;

   modport master (output word_valid, output word_data, output word_index,
                   input  word_ready);
   modport slave  (input  word_valid, input  word_data, input  word_index,
                   output word_ready);
endinterface

// File: rtl/tank_monitor_capture.sv
// -----------------------------------------------------------------------------
// tank_monitor_capture
// Snapshots one major cycle of a selected mercury tank's serial monitor
// stream into parallel words and presents them, with their minor-cycle
// index, on a valid/ready stream. Runs in digit time (one clk per digit).
//
// Ports:
//   clk          digit-rate clock
//   rst_n        asynchronous active-low reset
//   monitor_in   serial monitor bits, one per tank, digit-aligned
//   d0           digit pulse 0, high one clk at the start of each minor cycle
//   major_start  high one clk with d0 of word 0 of each major cycle
//   req/req_tank capture request and tank number, sampled while idle
//   continuous   (only with MONITOR_CONTINUOUS_EN) back-to-back snapshots
//   busy         capture armed or in progress
//   word_if      master side of the output word stream (2-entry buffer)
//   done         one-clk pulse after the last word of a major cycle is pushed
//   overrun      sticky, a completed word was dropped on a full buffer
//
// Optional feature macro: MONITOR_CONTINUOUS_EN
//   When defined, the continuous input keeps the capture running into the
//   next major cycle without re-arming. When undefined, captures are
//   single-shot and the port does not exist.
// -----------------------------------------------------------------------------
module tank_monitor_capture #(
   parameter int NUM_TANKS  = 32,
   parameter int WORD_BITS  = 36,
   parameter int TANK_WORDS = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_TANKS-1:0] monitor_in,
   input  logic                 d0,
   input  logic                 major_start,
   input  logic                 req,
   input  logic [4:0]           req_tank,
`ifdef MONITOR_CONTINUOUS_EN
   input  logic                 continuous,
`endif
   output logic                 busy,
   tank_monitor_if.master       word_if,
   output logic                 done,
   output logic                 overrun
);

   localparam int BIT_W  = $clog2(WORD_BITS);
   localparam int WCNT_W = $clog2(TANK_WORDS);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARM     = 2'd1,
      S_CAPTURE = 2'd2
   } state_t;

   state_t               state_q;
   logic [4:0]           tank_q;
   logic [BIT_W-1:0]     bit_cnt_q;
   logic [WCNT_W-1:0]    word_cnt_q;
   logic [WORD_BITS-1:0] shift_q;
   logic [WORD_BITS-1:0] shift_d;
   logic                 busy_q;
   logic                 done_q;
   logic                 overrun_q;

   logic [WORD_BITS-1:0] fifo_data_q [2];
   logic [WCNT_W-1:0]    fifo_idx_q  [2];
   logic                 wr_ptr_q;
   logic                 rd_ptr_q;
   logic [1:0]           count_q;
   logic [1:0]           count_d;

   logic                 sel_bit;
   logic                 req_ok;
   logic                 accept;
   logic [BIT_W-1:0]     bit_pos;
   logic                 word_done;
   logic                 last_word;
   logic                 pop;
   logic                 push_ok;
   logic                 drop;
   logic                 cont_en;

`ifdef MONITOR_CONTINUOUS_EN
   assign cont_en = continuous;
`else
   assign cont_en = 1'b0;
`endif

   assign sel_bit = monitor_in[tank_q];
   assign req_ok  = req && ({27'd0, req_tank} < 32'(NUM_TANKS));
   assign accept  = (state_q == S_IDLE) && req_ok;

   // d0 forces the digit position back to 0 so a slipped counter realigns
   // on the next minor cycle.
   always_comb begin
      bit_pos   = d0 ? '0 : bit_cnt_q;
      word_done = (state_q == S_CAPTURE) && (bit_pos == BIT_W'(WORD_BITS - 1));
      last_word = (word_cnt_q == WCNT_W'(TANK_WORDS - 1));
      shift_d   = shift_q;
      // Starting a new word clears leftovers so a resync never leaks bits
      // from the previous word.
      if (bit_pos == '0) begin
         shift_d = '0;
      end
      shift_d[bit_pos] = sel_bit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         tank_q     <= '0;
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         shift_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_ok) begin
                  tank_q  <= req_tank;
                  state_q <= S_ARM;
                  busy_q  <= 1'b1;
               end
            end
            S_ARM: begin
               // This clk carries digit 0 of word 0: it is the first bit.
               if (major_start && d0) begin
                  shift_q    <= shift_d;
                  bit_cnt_q  <= BIT_W'(1);
                  word_cnt_q <= '0;
                  state_q    <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               shift_q <= shift_d;
               if (word_done) begin
                  bit_cnt_q  <= '0;
                  word_cnt_q <= word_cnt_q + WCNT_W'(1);
                  if (last_word) begin
                     done_q     <= 1'b1;
                     word_cnt_q <= '0;
                     if (!cont_en) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                     end
                  end
               end else begin
                  bit_cnt_q <= bit_pos + BIT_W'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Output buffer: two entries; a push into a full buffer is only lost
   // when the head is not leaving on the same clk.
   assign pop     = (count_q != 2'd0) && word_if.word_ready;
   assign push_ok = word_done && ((count_q != 2'd2) || pop);
   assign drop    = word_done && (count_q == 2'd2) && !pop;

   always_comb begin
      count_d = count_q;
      if (push_ok && !pop) begin
         count_d = count_q + 2'd1;
      end else if (!push_ok && pop) begin
         count_d = count_q - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            fifo_data_q[i] <= '0;
            fifo_idx_q[i]  <= '0;
         end
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
         overrun_q <= 1'b0;
      end else begin
         count_q <= count_d;
         if (push_ok) begin
            fifo_data_q[wr_ptr_q] <= shift_d;
            fifo_idx_q[wr_ptr_q]  <= word_cnt_q;
            wr_ptr_q              <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         if (drop) begin
            overrun_q <= 1'b1;
         end else if (accept) begin
            overrun_q <= 1'b0;
         end
      end
   end

   assign word_if.word_valid = (count_q != 2'd0);
   assign word_if.word_data  = fifo_data_q[rd_ptr_q];
   assign word_if.word_index = fifo_idx_q[rd_ptr_q];
   assign busy               = busy_q;
   assign done               = done_q;
   assign overrun            = overrun_q;

endmodule

// File: tb/tb_tank_monitor_capture.sv
// -----------------------------------------------------------------------------
// tb_tank_monitor_capture
// Drives a synthetic set of mercury tanks (digit-aligned serial streams with
// d0/major_start) into tank_monitor_capture and checks the output stream
// against a transaction-level reference model, plus table-driven capture
// scenarios and hand-written reset / continuous-mode sequences.
// NUM_TANKS is reduced to 24 so that out-of-range tank numbers exist within
// the 5-bit req_tank field.
// -----------------------------------------------------------------------------
module tb_tank_monitor_capture;
   localparam int NT = 24;
   localparam int WB = 36;
   localparam int TW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NT-1:0] monitor_in;
   logic          d0;
   logic          major_start;
   logic          req;
   logic [4:0]    req_tank;
   logic          continuous;
   logic          busy;
   logic          done;
   logic          overrun;

   tank_monitor_if #(.WORD_BITS(WB), .IDX_W(4)) wif ();

   tank_monitor_capture #(.NUM_TANKS(NT), .WORD_BITS(WB), .TANK_WORDS(TW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .monitor_in  (monitor_in),
      .d0          (d0),
      .major_start (major_start),
      .req         (req),
      .req_tank    (req_tank),
`ifdef MONITOR_CONTINUOUS_EN
      .continuous  (continuous),
`endif
      .busy        (busy),
      .word_if     (wif),
      .done        (done),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- tank contents and stream generator ----------------
   logic [WB-1:0] tank_mem [NT][TW];
   int gcyc      = 0;
   int cur_digit = 0;
   int cur_word  = 0;
   int rdy_mode  = 0;   // 0: ready held 1, 1: ready held 0, 2: sparse random

   initial begin
      d0             = 1'b0;
      major_start    = 1'b0;
      monitor_in     = '0;
      wif.word_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cur_digit   = gcyc % WB;
         cur_word    = (gcyc / WB) % TW;
         d0          = (cur_digit == 0);
         major_start = (cur_digit == 0) && (cur_word == 0);
         for (int t = 0; t < NT; t++) monitor_in[t] = tank_mem[t][cur_word][cur_digit];
         gcyc++;
         case (rdy_mode)
            0:       wif.word_ready = 1'b1;
            1:       wif.word_ready = 1'b0;
            default: wif.word_ready = ($urandom_range(0, 63) < 3);
         endcase
      end
   end

   // ---------------- reference model ----------------
   // A capture arms on request, starts at the next major cycle, and word n
   // exists once its last digit has streamed past. A 2-deep queue stands in
   // for the output buffer.
   typedef struct packed {
      logic [3:0]    idx;
      logic [WB-1:0] data;
   } ent_t;

   ent_t mq[$];
   ent_t rx_log[$];
   ent_t pe;
   bit   m_armed = 0, m_capt = 0, m_done = 0, m_ovr = 0;
   int   m_tank = 0, m_n = 0;
   int   rx_cnt = 0, done_cnt = 0;
   bit   busy_seen = 0;
   bit   m_idle, m_pop, m_push, m_nd;
   logic [63:0] expv, actv;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mq.delete();
            m_armed = 0; m_capt = 0; m_done = 0; m_ovr = 0; m_n = 0;
         end else begin
            if (mq.size() != 0) begin
               expv = 64'({m_armed || m_capt, 1'b1, m_done, m_ovr, mq[0].idx, mq[0].data});
               actv = 64'({busy, wif.word_valid, done, overrun, wif.word_index, wif.word_data});
            end else begin
               expv = 64'({m_armed || m_capt, 1'b0, m_done, m_ovr, 4'd0, {WB{1'b0}}});
               actv = 64'({busy, wif.word_valid, done, overrun, 4'd0, {WB{1'b0}}});
            end
            check("cycle_outputs", actv, expv);
            if (wif.word_valid && wif.word_ready) begin
               rx_cnt++;
               rx_log.push_back({wif.word_index, wif.word_data});
            end
            if (done) done_cnt++;
            if (busy) busy_seen = 1;

            m_idle = !(m_armed || m_capt);
            m_pop  = (mq.size() != 0) && wif.word_ready;
            m_push = 0;
            m_nd   = 0;
            if (m_capt && cur_digit == WB - 1) begin
               pe     = {4'(m_n), tank_mem[m_tank][cur_word]};
               m_push = 1;
               m_n++;
               if (m_n == TW) begin
                  m_nd = 1;
                  m_n  = 0;
                  if (!continuous) m_capt = 0;
               end
            end
            if (m_armed && major_start && d0) begin
               m_armed = 0; m_capt = 1; m_n = 0;
            end
            if (m_idle && req && (int'(req_tank) < NT)) begin
               m_armed = 1; m_tank = int'(req_tank); m_ovr = 0;
            end
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
               if (mq.size() < 2) mq.push_back(pe);
               else m_ovr = 1;
            end
            m_done = m_nd;
         end
      end
   end

   // ---------------- scenarios ----------------
   typedef struct {
      logic [4:0] tank;
      int         rdy;
      bit         mid_req;
      int         exp_words;  // -1: not checked here
      int         exp_ovr;    // -1: not checked here
      bit         exp_busy;
   } scen_t;

   scen_t tbl[8];

   task automatic issue_req(input logic [4:0] t);
      @(posedge clk); #1;
      req = 1'b1; req_tank = t;
      @(posedge clk); #1;
      req = 1'b0;
   endtask

   task automatic wait_done(input int dn0, input int bound, input string name);
      int w = 0;
      while (done_cnt == dn0 && w < bound) begin
         @(posedge clk);
         w++;
      end
      #2;
      check(name, 64'(done_cnt - dn0), 64'd1);
   endtask

   task automatic run_scen(input scen_t s, input int k);
      int rx0, dn0, bad;
      rdy_mode = s.rdy;
      rx_log.delete();
      rx0 = rx_cnt;
      dn0 = done_cnt;
      busy_seen = 0;
      issue_req(s.tank);
      if (s.mid_req) begin
         repeat (40) @(posedge clk);
         issue_req(5'd5);
      end
      if (s.exp_busy) begin
         wait_done(dn0, 1400, $sformatf("s%0d_done", k));
      end else begin
         repeat (700) @(posedge clk);
         #2;
         check($sformatf("s%0d_no_done", k), 64'(done_cnt - dn0), 64'd0);
         check($sformatf("s%0d_no_valid", k), 64'(wif.word_valid), 64'd0);
      end
      if (s.rdy == 1) begin
         check($sformatf("s%0d_held_valid", k), 64'(wif.word_valid), 64'd1);
         check($sformatf("s%0d_held_index", k), 64'(wif.word_index), 64'd0);
      end
      if (s.exp_ovr >= 0) check($sformatf("s%0d_overrun", k), 64'(overrun), 64'(s.exp_ovr));
      rdy_mode = 0;
      repeat (8) @(posedge clk);
      #2;
      check($sformatf("s%0d_busy_seen", k), 64'(busy_seen), 64'(s.exp_busy));
      if (s.exp_words >= 0) begin
         check($sformatf("s%0d_words", k), 64'(rx_cnt - rx0), 64'(s.exp_words));
         bad = 0;
         for (int i = 0; i < rx_log.size(); i++)
            if (rx_log[i].idx !== 4'(i) || rx_log[i].data !== tank_mem[s.tank][i]) bad++;
         check($sformatf("s%0d_word_content", k), 64'(bad), 64'd0);
      end
   endtask

   initial begin
      int rx0, dn0, w;
      rst_n      = 1'b0;
      req        = 1'b0;
      req_tank   = '0;
      continuous = 1'b0;
      for (int t = 0; t < NT; t++)
         for (int n = 0; n < TW; n++)
            tank_mem[t][n] = (t == 3) ? WB'(n * 'h111) : WB'({$urandom, $urandom});

      tbl[0] = '{5'd3,  0, 0, 16,  0, 1};
      tbl[1] = '{5'd3,  1, 0,  2,  1, 1};
      tbl[2] = '{5'd28, 0, 0,  0,  1, 0};
      tbl[3] = '{5'd31, 0, 0,  0,  1, 0};
      tbl[4] = '{5'd3,  0, 1, 16,  0, 1};
      tbl[5] = '{5'd17, 2, 0, -1, -1, 1};
      tbl[6] = '{5'd23, 2, 1, -1, -1, 1};
      tbl[7] = '{5'd0,  0, 0, 16,  0, 1};

      repeat (3) @(posedge clk);
      #2;
      check("reset_outputs",
            64'({busy, wif.word_valid, done, overrun, wif.word_index, wif.word_data}), 64'd0);
      #1 rst_n = 1'b1;

      for (int k = 0; k < 8; k++) run_scen(tbl[k], k);

      // reset in the middle of word 7
      rdy_mode = 0;
      issue_req(5'd3);
      w = 0;
      while (!(m_capt && m_n == 7 && cur_digit == 18) && w < 1400) begin
         @(posedge clk); #2;
         w++;
      end
      check("mid_reset_reached_word7", 64'(w < 1400), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      check("mid_reset_outputs",
            64'({busy, wif.word_valid, done, overrun, wif.word_index, wif.word_data}), 64'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      rx0 = rx_cnt;
      dn0 = done_cnt;
      busy_seen = 0;
      repeat (700) @(posedge clk);
      #2;
      check("post_reset_no_words", 64'(rx_cnt - rx0), 64'd0);
      check("post_reset_no_done", 64'(done_cnt - dn0), 64'd0);
      check("post_reset_idle", 64'(busy_seen), 64'd0);
      run_scen(tbl[0], 8);

`ifdef MONITOR_CONTINUOUS_EN
      begin
         int bad;
         rdy_mode = 0;
         rx_log.delete();
         rx0 = rx_cnt;
         dn0 = done_cnt;
         continuous = 1'b1;
         issue_req(5'd3);
         wait_done(dn0, 1400, "cont_first_done");
         continuous = 1'b0;
         check("cont_busy_after_first", 64'(busy), 64'd1);
         wait_done(dn0 + 1, 700, "cont_second_done");
         repeat (8) @(posedge clk);
         #2;
         check("cont_words", 64'(rx_cnt - rx0), 64'd32);
         check("cont_done_pulses", 64'(done_cnt - dn0), 64'd2);
         bad = 0;
         for (int i = 0; i < rx_log.size(); i++)
            if (rx_log[i].idx !== 4'(i % TW) || rx_log[i].data !== tank_mem[3][i % TW]) bad++;
         check("cont_word_content", 64'(bad), 64'd0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
